// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial output buffer link.
// Used by both the transmitter and the receiver.
package serial_link_pkg;

  localparam int A_WIDTH_DEF = 7;
  localparam int D_WIDTH_DEF = 8;
  // start + two separators + stop around the address and data fields
  localparam int FRAME_BITS  = A_WIDTH_DEF + D_WIDTH_DEF + 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SEP_A = 3'd2,
    DATA  = 3'd3,
    SEP_D = 3'd4,
    STOP  = 3'd5
  } rx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_in_sync.sv
// Synchroniser for in_c/in_d/in_z with a registered in_c rising-edge event.
// d/z get the same depth as c so they stay aligned with the event.
module serial_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic c_i,
  input  logic d_i,
  input  logic z_i,
  output logic rise_o,
  output logic d_o,
  output logic z_o
);

  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] d_q, d_d;
  logic [STAGES-1:0] z_q, z_d;
  logic hist_q, hist_d;
  logic rise_q, rise_d;
  logic dout_q, dout_d;
  logic zout_q, zout_d;

  always_comb begin
    c_d    = {c_q[STAGES-2:0], c_i};
    d_d    = {d_q[STAGES-2:0], d_i};
    z_d    = {z_q[STAGES-2:0], z_i};
    hist_d = c_q[STAGES-1];
    rise_d = c_q[STAGES-1] & ~hist_q;
    dout_d = d_q[STAGES-1];
    zout_d = z_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      d_q    <= '0;
      z_q    <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      dout_q <= 1'b0;
      zout_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      z_q    <= z_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      dout_q <= dout_d;
      zout_q <= zout_d;
    end
  end

  assign rise_o = rise_q;
  assign d_o    = dout_q;
  assign z_o    = zout_q;

endmodule

// File: rtl/serial_in_receiver.sv
// Deserialises the OutD/OutC/Z link frame into an address/data pair.
// Oversampled on clk_in; one valid or frame_err pulse per frame.
module serial_in_receiver
  import serial_link_pkg::*;
#(
  parameter int A_WIDTH     = A_WIDTH_DEF,
  parameter int D_WIDTH     = D_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               in_c,
  input  logic               in_d,
  input  logic               in_z,
  output logic [A_WIDTH-1:0] a_out,
  output logic [D_WIDTH-1:0] d_out,
  output logic               valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int SH_W = max_int(A_WIDTH, D_WIDTH);
  localparam int CW   = $clog2(SH_W + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  logic ev, ds, zs;

  serial_in_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk_in),
    .reset (reset),
    .c_i   (in_c),
    .d_i   (in_d),
    .z_i   (in_z),
    .rise_o(ev),
    .d_o   (ds),
    .z_o   (zs)
  );

  rx_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [A_WIDTH-1:0] ah_q, ah_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [D_WIDTH-1:0] do_q, do_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ah_d    = ah_q;
    a_d     = a_q;
    do_d    = do_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;
    tmo_d   = (state_q == IDLE || ev) ? '0 : tmo_q + 1'b1;
    if (ev) begin
      case (state_q)
        IDLE: begin
          if (!zs && !ds) begin
            state_d = ADDR;
            cnt_d   = '0;
            sh_d    = '0;
          end
        end
        ADDR: begin
          if (zs) begin
            abort = 1'b1;
          end else begin
            sh_d = {sh_q[SH_W-2:0], ds};
            if (cnt_q == CW'(A_WIDTH - 1)) begin
              state_d = SEP_A;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SEP_A: begin
          if (!zs) begin
            abort = 1'b1;
          end else begin
            ah_d    = sh_q[A_WIDTH-1:0];
            sh_d    = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (zs) begin
            abort = 1'b1;
          end else begin
            sh_d = {sh_q[SH_W-2:0], ds};
            if (cnt_q == CW'(D_WIDTH - 1)) begin
              state_d = SEP_D;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SEP_D: begin
          if (!zs) abort = 1'b1;
          else state_d = STOP;
        end
        STOP: begin
          if (zs || ds) begin
            abort = 1'b1;
          end else begin
            a_d     = ah_q;
            do_d    = sh_q[D_WIDTH-1:0];
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      abort = 1'b1;
    end
    // Any abort leaves a_out/d_out untouched
    if (abort) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ah_q    <= '0;
      a_q     <= '0;
      do_q    <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ah_q    <= ah_d;
      a_q     <= a_d;
      do_q    <= do_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign a_out     = a_q;
  assign d_out     = do_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_in_receiver.sv
// Directed bench for serial_in_receiver: table of frames plus
// hand-written timeout, reset and back-to-back sequences.
module tb_serial_in_receiver;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          in_c   = 1'b0;
  logic          in_d   = 1'b0;
  logic          in_z   = 1'b0;
  logic [AW-1:0] a_out;
  logic [DW-1:0] d_out;
  logic          valid;
  logic          frame_err;
  logic          busy;

  serial_in_receiver #(
    .A_WIDTH    (AW),
    .D_WIDTH    (DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .in_c     (in_c),
    .in_d     (in_d),
    .in_z     (in_z),
    .a_out    (a_out),
    .d_out    (d_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int lat_v = -1;
  int lat_e = -1;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!reset) begin
      if (valid) begin
        vcnt++;
        lat_v = cyc - rise_cyc;
      end
      if (frame_err) begin
        ecnt++;
        lat_e = cyc - rise_cyc;
      end
      if (valid && frame_err) begin
        tests++;
        fails++;
        $display("FAIL excl: valid and frame_err both high at cycle %0d", cyc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic z);
    in_d = d;
    in_z = z;
    tick(2);
    in_c = 1'b1;
    rise_cyc = cyc;
    tick(5);
    in_c = 1'b0;
    tick(3);
  endtask

  // fault: 0 none, 1 SEP_A driven (not Z), 2 stop bit 1
  task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int fault);
    send_bit(1'b0, 1'b0);
    for (int i = AW - 1; i >= 0; i--) send_bit(a[i], 1'b0);
    if (fault == 1) begin
      send_bit(1'b0, 1'b0);
      return;
    end
    send_bit(1'b0, 1'b1);
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i], 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit((fault == 2) ? 1'b1 : 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            fault;
    int            exp_v;
    int            exp_e;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, e0;
    vecs[0] = '{7'h7F, 8'hFF, 0, 1, 0, 7'h7F, 8'hFF};
    vecs[1] = '{7'h41, 8'h9F, 0, 1, 0, 7'h41, 8'h9F};
    vecs[2] = '{7'h33, 8'hC3, 1, 0, 1, 7'h41, 8'h9F};
    vecs[3] = '{7'h2A, 8'h55, 0, 1, 0, 7'h2A, 8'h55};
    vecs[4] = '{7'h12, 8'h34, 2, 0, 1, 7'h2A, 8'h55};
    vecs[5] = '{7'h00, 8'h00, 0, 1, 0, 7'h00, 8'h00};

    tick(3);
    reset = 1'b0;
    @(negedge clk_in);
    chk("rst_a", a_out, 0);
    chk("rst_d", d_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    tick(1);

    for (int i = 0; i < 6; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      send_frame(vecs[i].a, vecs[i].d, vecs[i].fault);
      tick(2);
      chk($sformatf("v%0d_valid", i), vcnt - v0, vecs[i].exp_v);
      chk($sformatf("v%0d_err", i), ecnt - e0, vecs[i].exp_e);
      chk($sformatf("v%0d_a", i), a_out, vecs[i].exp_a);
      chk($sformatf("v%0d_d", i), d_out, vecs[i].exp_d);
      chk($sformatf("v%0d_busy", i), busy, 0);
      if (vecs[i].exp_v != 0) chk($sformatf("v%0d_lat", i), lat_v, SYNC + 2);
      else chk($sformatf("v%0d_elat", i), lat_e, SYNC + 2);
    end

    // in_c stalls after three address bits
    v0 = vcnt;
    e0 = ecnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("tmo_busy", busy, 1);
    for (int k = 0; k < TMO + 40 && ecnt == e0; k++) tick(1);
    tick(1);
    chk("tmo_err", ecnt - e0, 1);
    chk("tmo_lat", lat_e, SYNC + 2 + TMO);
    chk("tmo_valid", vcnt - v0, 0);
    chk("tmo_idle", busy, 0);

    // reset pulsed after five data bits
    v0 = vcnt;
    e0 = ecnt;
    send_bit(1'b0, 1'b0);
    for (int i = AW - 1; i >= 0; i--) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk_in);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_a", a_out, 0);
    tick(20);
    chk("rst_mid_valid", vcnt - v0, 0);
    chk("rst_mid_err", ecnt - e0, 0);
    send_frame(7'h01, 8'h80, 0);
    tick(2);
    chk("post_rst_valid", vcnt - v0, 1);
    chk("post_rst_a", a_out, 'h01);
    chk("post_rst_d", d_out, 'h80);

    // two frames with no gap between stop and start
    v0 = vcnt;
    e0 = ecnt;
    send_frame(7'h5A, 8'hA5, 0);
    chk("b2b1_a", a_out, 'h5A);
    chk("b2b1_d", d_out, 'hA5);
    send_frame(7'h3C, 8'h0F, 0);
    tick(2);
    chk("b2b_valid", vcnt - v0, 2);
    chk("b2b_err", ecnt - e0, 0);
    chk("b2b2_a", a_out, 'h3C);
    chk("b2b2_d", d_out, 'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_in_receiver.md
Name: serial_in_receiver

Overview:
- Receiving end of the serial output buffer link. Deserialises the OutD/OutC frame back into a 7-bit address and an 8-bit data word.
- Frame format:
  - start bit 0
  - A, MSB first
  - Z separator
  - D, MSB first
  - Z separator
  - stop bit 0
- Sits at the input pads of the consuming chip. Oversamples the link with the local clock and presents one word pair per frame, with valid/error pulses.

Parameters:
- A_WIDTH, 7, address field width in bits.
- D_WIDTH, 8, data field width in bits.
- SYNC_STAGES, 2, synchroniser depth applied to in_c, in_d and in_z (min 2).
- TIMEOUT, 64, clk_in cycles without an in_c rising edge before an in-progress frame is aborted.

Ports:
- clk_in  input  1  local system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_c  input  1  serial clock from the transmitter (OutC); asynchronous to clk_in.
- in_d  input  1  serial data (OutD); valid when sampled at an in_c rising edge.
- in_z  input  1  pad high-impedance indicator; 1 = line not driven (the Z separator); asynchronous.
- a_out  output  A_WIDTH  last received address.
- d_out  output  D_WIDTH  last received data.
- valid  output  1  one-cycle pulse: a_out/d_out updated with a good frame.
- frame_err  output  1  one-cycle pulse: frame aborted.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clocking and reset
  - One clock, clk_in. Reset is synchronous and active-high.
  - Reset values: a_out=0, d_out=0, valid=0, frame_err=0, busy=0. State=IDLE, shift register=0, bit counter=0, timeout counter=0, all synchroniser flops=0.
  - Reset asserted mid-frame discards the frame. No valid or frame_err is issued.
- Synchronisation
  - in_c, in_d and in_z each pass through SYNC_STAGES flops plus one history flop on in_c.
  - The bit event is a 0->1 transition at the synchroniser output. in_d/in_z are delayed identically, so they are aligned with the in_c edge.
  - in_c high or low time shorter than 2 clk_in cycles is unsupported.
- FSM states: IDLE, ADDR, SEP_A, DATA, SEP_D, STOP. One bit is consumed per bit event.
  - IDLE: on an event with z=0 and d=0 (start bit) -> ADDR, counter=0. An event with d=1 or z=1 is ignored; stay in IDLE.
  - ADDR: the event must have z=0. Shift d into the shift register LSB (shift left). After A_WIDTH bits -> SEP_A.
  - SEP_A: the event must have z=1. Latch the shifted address into a holding register, clear the shift register -> DATA.
  - DATA: same as ADDR with D_WIDTH bits -> SEP_D.
  - SEP_D: the event must have z=1 -> STOP.
  - STOP: the event must have z=0 and d=0. Then load a_out and d_out, pulse valid for 1 cycle -> IDLE.
- Error handling
  - Any violated expectation (Z in a data bit, non-Z separator, stop bit 1) pulses frame_err -> IDLE. a_out/d_out are unchanged.
- Timeout
  - The timeout counter clears on every bit event and in IDLE; it counts otherwise.
  - Reaching TIMEOUT-1 in a non-IDLE state pulses frame_err -> IDLE.
- Output timing
  - valid and frame_err are asserted in the cycle after the clk_in edge that registers the offending or final bit event. They are never both high.
  - a_out/d_out hold their values until the next good frame.
- Back-to-back frames: a start bit arriving on the first event after STOP is accepted. There are no dead cycles.
- Latency: from an in_c pin rise to its bit event is SYNC_STAGES+1 clk_in cycles; valid follows 1 cycle later.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding typedef (IDLE..STOP)
  - default A_WIDTH/D_WIDTH constants
  - frame bit count constant: A_WIDTH+D_WIDTH+4 (start, two separators, stop)
- These are shared with the transmitter.
- Sub-module: serial_in_sync, a parameterised 3-bit synchroniser with in_c rising-edge detect. Instantiated once.

Test Plan:
- Reset 3 cycles, then a frame A=7'b1111111, D=8'b11111111, in_c period 10 clk_in -> one valid pulse; a_out=7'h7F, d_out=8'hFF; frame_err never high.
- Frame A=7'b1000001, D=8'b10011111 -> valid; a_out=7'h41, d_out=8'h9F. Check latency from the stop-bit in_c rise to valid = SYNC_STAGES+2 cycles.
- Frame with in_z=0 during the SEP_A bit -> frame_err pulse at that bit; a_out/d_out keep their prior values; busy drops; a following good frame (A=7'h2A, D=8'h55) is received correctly.
- Good frame, then stop bit driven as 1 -> frame_err, no valid.
- in_c stops after 3 address bits -> frame_err exactly TIMEOUT cycles after the last event; return to IDLE.
- Reset pulsed after 5 data bits -> no valid or frame_err; busy=0 next cycle; next frame (A=7'h01, D=8'h80) is decoded correctly. Also two frames back-to-back -> two valid pulses with correct values.
